// File: rtl/vga_graph_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared mode encodings, conf field positions and clear-engine
//               state type for the VGA graphics framebuffer.
// Revision    : 1.0 - initial parametrised framebuffer release
// ============================================================================
package vga_pkg;

  // Display mode, conf[1:0]
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_FILL  = 2'b01,
    MODE_PIXEL = 2'b10,
    MODE_TILE  = 2'b11
  } mode_e;

  // conf register layout: mode in the low two bits, fill colour right above
  localparam int CONF_MODE_LSB  = 0;
  localparam int CONF_MODE_W    = 2;
  localparam int CONF_COLOR_LSB = 2;

  // Clear engine states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Only pixel and tile modes fetch colour from the RAM
  function automatic logic mode_uses_ram(input mode_e m);
    return (m == MODE_PIXEL) || (m == MODE_TILE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_fb_ram.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_ram
// Description : Single-port synchronous pixel RAM with registered read.
//               Contents are not reset.
// Revision    : 1.0 - initial parametrised framebuffer release
// ============================================================================
module vga_fb_ram #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [COLOR_W-1:0] wdata,
  output logic [COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] mem_q [2**ADDR_W];
  logic [COLOR_W-1:0] rdata_q;

  // One access per cycle: either a write or a registered read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vga_graph_fb.sv
`default_nettype none
// ============================================================================
// Module      : vga_graph_fb
// Description : Framebuffer controller. CPU writes are queued in a small FIFO
//               and retired when the scan-out is not using the RAM port; a
//               clear engine fills every word of the current mode. Scan-out
//               has a fixed three-cycle latency with blank masking.
// Revision    : 1.0 - initial parametrised framebuffer release
// ============================================================================
module vga_graph_fb
  import vga_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COLOR_W    = 12,
  parameter int ADDR_W     = 19,
  parameter int TILE_LOG2  = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        conf,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [COLOR_W-1:0] data,
  output logic               wr_full,
  input  logic               clr_req,
  output logic               clr_busy,
  input  logic [9:0]         vga_column,
  input  logic [8:0]         vga_row,
  input  logic               vga_active,
  output logic [COLOR_W-1:0] color_out
);

  localparam int          FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int          FIFO_CW = FIFO_AW + 1;
  localparam int          FIFO_W  = ADDR_W + COLOR_W;
  localparam logic [31:0] N_PIXEL = 32'(H_RES * V_RES);
  localparam logic [31:0] H_TILES = 32'(H_RES >> TILE_LOG2);
  localparam logic [31:0] N_TILE  = H_TILES * 32'(V_RES >> TILE_LOG2);

  // --------------------------------------------------------------------------
  // conf decode
  // --------------------------------------------------------------------------
  mode_e              cur_mode;
  logic [COLOR_W-1:0] cur_fill;

  assign cur_mode = mode_e'(conf[CONF_MODE_LSB +: CONF_MODE_W]);
  assign cur_fill = conf[CONF_COLOR_LSB +: COLOR_W];

  generate
    if (CONF_COLOR_LSB + COLOR_W < 32) begin : g_conf_reserved
      logic unused_conf_reserved;
      assign unused_conf_reserved = ^conf[31:CONF_COLOR_LSB+COLOR_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Word count and scan address for the mode currently on conf
  // --------------------------------------------------------------------------
  logic [31:0]       word_count;
  logic [31:0]       scan_full;
  logic [ADDR_W-1:0] scan_addr;

  // Tile mode addresses one word per 2^TILE_LOG2 square; other modes per pixel
  always_comb begin
    word_count = N_PIXEL;
    scan_full  = 32'(vga_row) * 32'(H_RES) + 32'(vga_column);
    if (cur_mode == MODE_TILE) begin
      word_count = N_TILE;
      scan_full  = (32'(vga_row) >> TILE_LOG2) * H_TILES
                 + (32'(vga_column) >> TILE_LOG2);
    end
  end

  assign scan_addr = ADDR_W'(scan_full);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]  s1_addr_q,   s1_addr_d;
  logic               s1_active_q, s1_active_d;
  mode_e              s1_mode_q,   s1_mode_d;
  logic [COLOR_W-1:0] s1_fill_q,   s1_fill_d;
  logic               s2_active_q, s2_active_d;
  mode_e              s2_mode_q,   s2_mode_d;
  logic [COLOR_W-1:0] s2_fill_q,   s2_fill_d;
  logic [COLOR_W-1:0] color_out_q, color_out_d;

  logic [FIFO_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_W-1:0]  fifo_mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0] count_q,  count_d;
  logic               wr_full_q, wr_full_d;

  clr_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q,   clr_cnt_d;
  logic [ADDR_W-1:0]  clr_last_q,  clr_last_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;

  // --------------------------------------------------------------------------
  // RAM port arbitration: scan read, then clear write, then FIFO drain
  // --------------------------------------------------------------------------
  logic               ram_rd;
  logic               ram_en;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [COLOR_W-1:0] ram_wdata;
  logic [COLOR_W-1:0] ram_rdata;
  logic               clr_grant;
  logic               fifo_enq;
  logic               fifo_deq;
  logic               fifo_empty;
  logic [ADDR_W-1:0]  head_addr;
  logic [COLOR_W-1:0] head_data;
  logic               head_in_range;

  assign ram_rd        = s1_active_q && mode_uses_ram(s1_mode_q);
  assign fifo_empty    = (count_q == '0);
  assign fifo_enq      = we && !wr_full_q;
  assign head_addr     = fifo_mem_q[rd_ptr_q][FIFO_W-1:COLOR_W];
  assign head_data     = fifo_mem_q[rd_ptr_q][COLOR_W-1:0];
  assign head_in_range = (32'(head_addr) < word_count);

  // Grant the single port; out-of-range FIFO heads are popped without a write
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = s1_addr_q;
    ram_wdata = clr_color_q;
    clr_grant = 1'b0;
    fifo_deq  = 1'b0;
    if (ram_rd) begin
      ram_en = 1'b1;
    end else if (state_q == CLEAR) begin
      clr_grant = 1'b1;
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt_q;
    end else if (!fifo_empty) begin
      fifo_deq = 1'b1;
      if (head_in_range) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = head_addr;
        ram_wdata = head_data;
      end
    end
  end

  vga_fb_ram #(
    .ADDR_W  (ADDR_W),
    .COLOR_W (COLOR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // CPU write FIFO; full flag is registered so a write seen while full is
  // dropped even if the head drains in the same cycle
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (fifo_enq) begin
      fifo_mem_d[wr_ptr_q] = {addr, data};
      wr_ptr_d             = wr_ptr_q + FIFO_AW'(1);
    end
    if (fifo_deq) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    if (fifo_enq && !fifo_deq) begin
      count_d = count_q + FIFO_CW'(1);
    end else if (fifo_deq && !fifo_enq) begin
      count_d = count_q - FIFO_CW'(1);
    end
    wr_full_d = (count_d == FIFO_CW'(FIFO_DEPTH));
  end

  // --------------------------------------------------------------------------
  // Clear engine: latch word count and colour on entry, then walk the words
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_last_d  = clr_last_q;
    clr_color_d = clr_color_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          clr_last_d  = ADDR_W'(word_count - 32'd1);
          clr_color_d = cur_fill;
        end
      end
      CLEAR: begin
        if (clr_grant) begin
          if (clr_cnt_q == clr_last_q) begin
            state_d = IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Scan pipeline: S1 address/active, S2 RAM read, S3 output colour
  // --------------------------------------------------------------------------
  always_comb begin
    s1_addr_d   = scan_addr;
    s1_active_d = vga_active;
    s1_mode_d   = cur_mode;
    s1_fill_d   = cur_fill;
    s2_active_d = s1_active_q;
    s2_mode_d   = s1_mode_q;
    s2_fill_d   = s1_fill_q;
    color_out_d = '0;
    if (s2_active_q) begin
      case (s2_mode_q)
        MODE_OFF:  color_out_d = '0;
        MODE_FILL: color_out_d = s2_fill_q;
        default:   color_out_d = ram_rdata;
      endcase
    end
  end

  // Control and pipeline registers, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_addr_q   <= '0;
      s1_active_q <= 1'b0;
      s1_mode_q   <= MODE_OFF;
      s1_fill_q   <= '0;
      s2_active_q <= 1'b0;
      s2_mode_q   <= MODE_OFF;
      s2_fill_q   <= '0;
      color_out_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_full_q   <= 1'b0;
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      clr_last_q  <= '0;
      clr_color_q <= '0;
    end else begin
      s1_addr_q   <= s1_addr_d;
      s1_active_q <= s1_active_d;
      s1_mode_q   <= s1_mode_d;
      s1_fill_q   <= s1_fill_d;
      s2_active_q <= s2_active_d;
      s2_mode_q   <= s2_mode_d;
      s2_fill_q   <= s2_fill_d;
      color_out_q <= color_out_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_full_q   <= wr_full_d;
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_last_q  <= clr_last_d;
      clr_color_q <= clr_color_d;
    end
  end

  // FIFO storage needs no reset; only entries between the pointers are read
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign wr_full   = wr_full_q;
  assign clr_busy  = (state_q == CLEAR);
  assign color_out = color_out_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_graph_fb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_graph_fb
// Description : Directed self-checking bench for vga_graph_fb.
// Revision    : 1.0 - initial parametrised framebuffer release
// ============================================================================
module tb_vga_graph_fb;

  logic        clk;
  logic        rst;
  logic [31:0] conf;
  logic        we;
  logic [18:0] addr;
  logic [11:0] data;
  logic        wr_full;
  logic        clr_req;
  logic        clr_busy;
  logic [9:0]  vga_column;
  logic [8:0]  vga_row;
  logic        vga_active;
  logic [11:0] color_out;

  int tests;
  int fails;

  // conf words: mode in [1:0], fill colour in [13:2]
  localparam logic [31:0] CONF_OFF   = 32'h0000_0000;
  localparam logic [31:0] CONF_PIXEL = 32'h0000_0002;
  localparam logic [31:0] CONF_TILE  = 32'h0000_0003;
  localparam logic [31:0] CONF_T00F  = 32'h0000_003F; // tile, fill 12'h00F
  localparam logic [31:0] CONF_T0A0  = 32'h0000_0283; // tile, fill 12'h0A0
  localparam logic [31:0] CONF_F777  = 32'h0000_1DDD; // fill, fill 12'h777

  vga_graph_fb dut (
    .clk        (clk),
    .rst        (rst),
    .conf       (conf),
    .we         (we),
    .addr       (addr),
    .data       (data),
    .wr_full    (wr_full),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .vga_column (vga_column),
    .vga_row    (vga_row),
    .vga_active (vga_active),
    .color_out  (color_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus changes and sampling both happen 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [18:0] a, input logic [11:0] d);
    we   = 1'b1;
    addr = a;
    data = d;
    tick();
    we   = 1'b0;
  endtask

  // Present one scan position for a single cycle, return colour 3 cycles later
  task automatic do_scan(input logic [8:0] row, input logic [9:0] col,
                         input logic act, output logic [11:0] c);
    vga_row    = row;
    vga_column = col;
    vga_active = act;
    tick();
    vga_active = 1'b0;
    tick();
    tick();
    c = color_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if (color_out !== 12'h000) begin
      fails++;
      $display("FAIL reset_color: got %h expected %h", color_out, 12'h000);
    end
    tests++;
    if (wr_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_wr_full: got %b expected 0", wr_full);
    end
    tests++;
    if (clr_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_clr_busy: got %b expected 0", clr_busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pixel();
    logic [11:0] c;
    conf = CONF_PIXEL;
    cpu_write(19'd641, 12'hF00);
    repeat (3) tick();
    do_scan(9'd1, 10'd1, 1'b1, c);
    tests++;
    if (c !== 12'hF00) begin
      fails++;
      $display("FAIL pixel_active: got %h expected %h", c, 12'hF00);
    end
    do_scan(9'd1, 10'd1, 1'b0, c);
    tests++;
    if (c !== 12'h000) begin
      fails++;
      $display("FAIL pixel_blank: got %h expected %h", c, 12'h000);
    end
  endtask

  task automatic test_tile();
    logic [11:0] c;
    conf = CONF_TILE;
    cpu_write(19'd21, 12'h0F0);
    repeat (3) tick();
    do_scan(9'd40, 10'd35, 1'b1, c);
    tests++;
    if (c !== 12'h0F0) begin
      fails++;
      $display("FAIL tile_40_35: got %h expected %h", c, 12'h0F0);
    end
    do_scan(9'd63, 10'd63, 1'b1, c);
    tests++;
    if (c !== 12'h0F0) begin
      fails++;
      $display("FAIL tile_63_63: got %h expected %h", c, 12'h0F0);
    end
  endtask

  task automatic test_fifo_full();
    logic [11:0] c;
    conf = CONF_PIXEL;
    // marker at the address the dropped ninth write targets
    cpu_write(19'd1008, 12'h555);
    repeat (3) tick();
    vga_row    = 9'd0;
    vga_column = 10'd0;
    vga_active = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      we   = 1'b1;
      addr = 19'(1000 + i);
      data = 12'(i + 1);
      tick();
      if (i == 6) begin
        tests++;
        if (wr_full !== 1'b0) begin
          fails++;
          $display("FAIL fifo_not_full_at_7: got %b expected 0", wr_full);
        end
      end
      if (i == 7) begin
        tests++;
        if (wr_full !== 1'b1) begin
          fails++;
          $display("FAIL fifo_full_at_8: got %b expected 1", wr_full);
        end
      end
    end
    we         = 1'b0;
    vga_active = 1'b0;
    tick();
    tests++;
    if (wr_full !== 1'b1) begin
      fails++;
      $display("FAIL fifo_full_before_drain: got %b expected 1", wr_full);
    end
    tick();
    tests++;
    if (wr_full !== 1'b0) begin
      fails++;
      $display("FAIL fifo_free_after_drain: got %b expected 0", wr_full);
    end
    repeat (10) tick();
    do_scan(9'd1, 10'd360, 1'b1, c);
    tests++;
    if (c !== 12'h001) begin
      fails++;
      $display("FAIL fifo_first_entry: got %h expected %h", c, 12'h001);
    end
    do_scan(9'd1, 10'd367, 1'b1, c);
    tests++;
    if (c !== 12'h008) begin
      fails++;
      $display("FAIL fifo_eighth_entry: got %h expected %h", c, 12'h008);
    end
    do_scan(9'd1, 10'd368, 1'b1, c);
    tests++;
    if (c !== 12'h555) begin
      fails++;
      $display("FAIL fifo_ninth_dropped: got %h expected %h", c, 12'h555);
    end
  endtask

  task automatic test_clear();
    logic [11:0] c;
    int n;
    int bad;
    conf       = CONF_T00F;
    vga_active = 1'b0;
    clr_req    = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 2000) begin
      n++;
      tick();
    end
    tests++;
    if (n != 300) begin
      fails++;
      $display("FAIL clear_busy_cycles: got %0d expected 300", n);
    end
    bad = 0;
    for (int ty = 0; ty < 15; ty++) begin
      for (int tx = 0; tx < 20; tx++) begin
        do_scan(9'(ty * 32), 10'(tx * 32), 1'b1, c);
        if (c !== 12'h00F) bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL clear_all_tiles: got %0d wrong tiles expected 0", bad);
    end
  endtask

  task automatic test_clear_toggle();
    logic [11:0] c;
    int n;
    conf       = CONF_T0A0;
    vga_row    = 9'd0;
    vga_column = 10'd0;
    vga_active = 1'b0;
    clr_req    = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 2000) begin
      n++;
      vga_active = ~vga_active;
      tick();
    end
    vga_active = 1'b0;
    tests++;
    if (n < 595 || n > 605) begin
      fails++;
      $display("FAIL clear_toggle_cycles: got %0d expected 595..605", n);
    end
    repeat (3) tick();
    do_scan(9'd448, 10'd608, 1'b1, c);
    tests++;
    if (c !== 12'h0A0) begin
      fails++;
      $display("FAIL clear_toggle_last_tile: got %h expected %h", c, 12'h0A0);
    end
  endtask

  task automatic test_clear_with_write();
    logic [11:0] c;
    int n;
    conf       = CONF_T00F;
    vga_active = 1'b0;
    clr_req    = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 2000) begin
      n++;
      we      = (n == 10);
      addr    = 19'd5;
      data    = 12'hABC;
      clr_req = (n == 50);
      tick();
    end
    we      = 1'b0;
    clr_req = 1'b0;
    tests++;
    if (n != 300) begin
      fails++;
      $display("FAIL clear_second_req_ignored: got %0d expected 300", n);
    end
    repeat (4) tick();
    do_scan(9'd0, 10'd160, 1'b1, c);
    tests++;
    if (c !== 12'hABC) begin
      fails++;
      $display("FAIL clear_queued_write_wins: got %h expected %h", c, 12'hABC);
    end
    do_scan(9'd0, 10'd192, 1'b1, c);
    tests++;
    if (c !== 12'h00F) begin
      fails++;
      $display("FAIL clear_neighbour_tile: got %h expected %h", c, 12'h00F);
    end
  endtask

  task automatic test_reset_mid_clear();
    conf    = CONF_T00F;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    tests++;
    if (clr_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_aborts_clear: got %b expected 0", clr_busy);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    logic [11:0] c;
    conf = CONF_PIXEL;
    cpu_write(19'd307200, 12'hEEE);
    cpu_write(19'd642, 12'h123);
    repeat (4) tick();
    do_scan(9'd480, 10'd0, 1'b1, c);
    tests++;
    if (c === 12'hEEE) begin
      fails++;
      $display("FAIL oob_write_discarded: got %h required not %h", c, 12'hEEE);
    end
    do_scan(9'd1, 10'd2, 1'b1, c);
    tests++;
    if (c !== 12'h123) begin
      fails++;
      $display("FAIL oob_next_write: got %h expected %h", c, 12'h123);
    end
  endtask

  task automatic test_modes();
    logic [11:0] c;
    conf = CONF_OFF;
    do_scan(9'd1, 10'd1, 1'b1, c);
    tests++;
    if (c !== 12'h000) begin
      fails++;
      $display("FAIL mode_off: got %h expected %h", c, 12'h000);
    end
    conf = CONF_F777;
    do_scan(9'd100, 10'd200, 1'b1, c);
    tests++;
    if (c !== 12'h777) begin
      fails++;
      $display("FAIL mode_fill_active: got %h expected %h", c, 12'h777);
    end
    do_scan(9'd100, 10'd200, 1'b0, c);
    tests++;
    if (c !== 12'h000) begin
      fails++;
      $display("FAIL mode_fill_blank: got %h expected %h", c, 12'h000);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    conf       = CONF_OFF;
    we         = 1'b0;
    addr       = '0;
    data       = '0;
    clr_req    = 1'b0;
    vga_column = '0;
    vga_row    = '0;
    vga_active = 1'b0;
    test_reset();
    test_pixel();
    test_tile();
    test_fifo_full();
    test_clear();
    test_clear_toggle();
    test_clear_with_write();
    test_reset_mid_clear();
    test_out_of_range();
    test_modes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
